// File: rtl/mux_scan_sequencer.sv
// Steps a 32:1 mux selector over a wrapping range and samples one line per index into a capture word.
// Each line takes SETTLE_CYCLES+1 cycles; start is dropped while busy (no queuing, no backpressure).
module mux_scan_sequencer #(
  parameter int SEL_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 1,
  localparam int NUM_LINES    = 2**SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] first_sel,
  input  logic [SEL_WIDTH-1:0] last_sel,
  output logic [SEL_WIDTH-1:0] selector_bits,
  input  logic                 output_line,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output logic [SEL_WIDTH-1:0] sample_index,
  output logic                 sample_bit,
  output logic [NUM_LINES-1:0] captured
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [SEL_WIDTH-1:0] last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      selector_bits <= '0;
      captured      <= '0;
      cnt           <= '0;
      last_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_q        <= last_sel;
            selector_bits <= first_sel;
            captured      <= '0;
            cnt           <= SETTLE_INIT;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 4'd1;
        end
        SAMPLE: begin
          captured[selector_bits] <= output_line;
          if (selector_bits == last_q) begin
            state <= DONE;
          end else begin
            // natural overflow of the selector gives the 31->0 wrap
            selector_bits <= selector_bits + SEL_WIDTH'(1);
            cnt           <= SETTLE_INIT;
            state         <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign sample_valid = (state == SAMPLE);
  assign sample_index = selector_bits;
  assign sample_bit   = output_line;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: dut1 uses SETTLE_CYCLES=1, dut2 uses SETTLE_CYCLES=4 with settle-phase glitching.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2, glitch;
  logic [4:0]  first1, last1, first2, last2;
  logic [31:0] mux1, mux2;
  logic [4:0]  sel1, idx1, sel2, idx2;
  logic        line1, line2, busy1, busy2, done1, done2, sv1, sv2, bit1, bit2;
  logic [31:0] cap1, cap2;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign line1 = mux1[sel1];
  assign line2 = (glitch && !sv2) ? ~mux2[sel2] : mux2[sel2];

  mux_scan_sequencer #(.SEL_WIDTH(5), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .first_sel(first1), .last_sel(last1),
    .selector_bits(sel1), .output_line(line1), .busy(busy1), .done(done1),
    .sample_valid(sv1), .sample_index(idx1), .sample_bit(bit1), .captured(cap1));

  mux_scan_sequencer #(.SEL_WIDTH(5), .SETTLE_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .first_sel(first2), .last_sel(last2),
    .selector_bits(sel2), .output_line(line2), .busy(busy2), .done(done2),
    .sample_valid(sv2), .sample_index(idx2), .sample_bit(bit2), .captured(cap2));

  // Runs one dut1 scan and reports what was observed; the calling test judges it.
  // inj: 0 none, 1 pulse start (first=5) while selector is 3, 2 pulse start during done.
  task automatic do_scan1(input logic [4:0] f, input logic [4:0] l, input int inj,
                          output int dc, output int nsv, output int oe, output int nd,
                          output int bc, output logic [31:0] c0);
    bit         injd;
    logic [4:0] ei;
    dc = -1; nsv = 0; oe = 0; nd = 0; bc = 0; injd = 0;
    first1 = f; last1 = l; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; first1 = ~f; last1 = ~l;
    c0 = cap1;
    for (int c = 0; c < 300; c++) begin
      start1 = 1'b0;
      if (busy1) bc++;
      if (sv1) begin
        ei = f + 5'(nsv);
        if (idx1 !== ei || sel1 !== ei || bit1 !== mux1[ei]) oe++;
        nsv++;
      end
      if (done1) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (!busy1) break;
      if (inj == 1 && !injd && sel1 == 5'd3) begin start1 = 1'b1; first1 = 5'd5; injd = 1; end
      if (inj == 2 && !injd && done1) begin start1 = 1'b1; injd = 1; end
      @(posedge clk); #1;
    end
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (sel1 !== 5'd0)  begin n_fail++; $display("FAIL reset_sel1: got %0h want 0", sel1); end
    n_cmp++; if (cap1 !== 32'd0) begin n_fail++; $display("FAIL reset_cap1: got %0h want 0", cap1); end
    n_cmp++; if ({busy1, done1, sv1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags1: got %b want 000", {busy1, done1, sv1}); end
    n_cmp++; if ({busy2, done2, sv2, sel2} !== 8'd0 || cap2 !== 32'd0) begin n_fail++; $display("FAIL reset_dut2: got %b/%0h want 0/0", {busy2, done2, sv2, sel2}, cap2); end
  endtask

  task automatic test_full();
    int dc, nsv, oe, nd, bc; logic [31:0] c0;
    mux1 = 32'hA5A5_3C3C;
    do_scan1(5'd0, 5'd31, 0, dc, nsv, oe, nd, bc, c0);
    n_cmp++; if (cap1 !== 32'hA5A5_3C3C) begin n_fail++; $display("FAIL full_cap: got %0h want a5a53c3c", cap1); end
    n_cmp++; if (dc !== 64) begin n_fail++; $display("FAIL full_done_cycle: got %0d want 64", dc); end
    n_cmp++; if (nsv !== 32) begin n_fail++; $display("FAIL full_samples: got %0d want 32", nsv); end
    n_cmp++; if (oe !== 0) begin n_fail++; $display("FAIL full_order: got %0d errors want 0", oe); end
    n_cmp++; if (nd !== 1 || bc !== 65) begin n_fail++; $display("FAIL full_done_busy: got %0d/%0d want 1/65", nd, bc); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (cap1 !== 32'hA5A5_3C3C || sel1 !== 5'd31 || busy1 !== 1'b0) begin n_fail++; $display("FAIL full_idle_hold: got %0h/%0d/%b want a5a53c3c/31/0", cap1, sel1, busy1); end
  endtask

  task automatic test_wrap();
    int dc, nsv, oe, nd, bc; logic [31:0] c0;
    mux1 = 32'hFFFF_FFFF;
    do_scan1(5'd30, 5'd1, 0, dc, nsv, oe, nd, bc, c0);
    n_cmp++; if (c0 !== 32'd0) begin n_fail++; $display("FAIL wrap_clear: got %0h want 0", c0); end
    n_cmp++; if (cap1 !== 32'hC000_0003) begin n_fail++; $display("FAIL wrap_cap: got %0h want c0000003", cap1); end
    n_cmp++; if (nsv !== 4 || oe !== 0) begin n_fail++; $display("FAIL wrap_samples: got %0d/%0d want 4/0", nsv, oe); end
    n_cmp++; if (dc !== 8 || nd !== 1) begin n_fail++; $display("FAIL wrap_done: got %0d/%0d want 8/1", dc, nd); end
  endtask

  task automatic test_single();
    int dc, nsv, oe, nd, bc; logic [31:0] c0;
    mux1 = 32'h0000_0080;
    do_scan1(5'd7, 5'd7, 2, dc, nsv, oe, nd, bc, c0);
    n_cmp++; if (cap1 !== 32'h0000_0080) begin n_fail++; $display("FAIL single_cap: got %0h want 80", cap1); end
    n_cmp++; if (nsv !== 1 || oe !== 0) begin n_fail++; $display("FAIL single_samples: got %0d/%0d want 1/0", nsv, oe); end
    n_cmp++; if (bc !== 3 || dc !== 2) begin n_fail++; $display("FAIL single_busy: got %0d/%0d want 3/2", bc, dc); end
    @(posedge clk); #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL single_start_in_done: got busy %b want 0", busy1); end
  endtask

  task automatic test_reset_mid();
    int dc, nsv, oe, nd, bc, bad; logic [31:0] c0;
    mux1 = 32'hFFFF_FFFF; first1 = 5'd0; last1 = 5'd31; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sel1 == 5'd10 && !sv1) break;
      @(posedge clk); #1;
    end
    n_cmp++; if (sel1 !== 5'd10 || busy1 !== 1'b1 || sv1 !== 1'b0) begin n_fail++; $display("FAIL rst_reach_settle10: got %0d/%b/%b want 10/1/0", sel1, busy1, sv1); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (sel1 !== 5'd0 || cap1 !== 32'd0) begin n_fail++; $display("FAIL rst_async_clear: got %0d/%0h want 0/0", sel1, cap1); end
    n_cmp++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL rst_async_flags: got %b%b want 00", busy1, done1); end
    @(posedge clk); #1; reset = 1'b0;
    bad = 0;
    repeat (70) begin
      if (busy1 || done1) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d busy/done cycles want 0", bad); end
    mux1 = 32'h0000_0014;
    do_scan1(5'd2, 5'd4, 0, dc, nsv, oe, nd, bc, c0);
    n_cmp++; if (cap1 !== 32'h0000_0014) begin n_fail++; $display("FAIL rst_rescan_cap: got %0h want 14", cap1); end
    n_cmp++; if (dc !== 6 || nsv !== 3 || oe !== 0 || nd !== 1) begin n_fail++; $display("FAIL rst_rescan_timing: got %0d/%0d/%0d/%0d want 6/3/0/1", dc, nsv, oe, nd); end
  endtask

  task automatic test_back_to_back();
    int dc, nsv, oe, nd, bc; logic [31:0] c0;
    mux1 = 32'h1234_5678;
    do_scan1(5'd0, 5'd31, 1, dc, nsv, oe, nd, bc, c0);
    n_cmp++; if (cap1 !== 32'h1234_5678) begin n_fail++; $display("FAIL busy_start_cap: got %0h want 12345678", cap1); end
    n_cmp++; if (dc !== 64 || nsv !== 32 || oe !== 0 || nd !== 1) begin n_fail++; $display("FAIL busy_start_scan: got %0d/%0d/%0d/%0d want 64/32/0/1", dc, nsv, oe, nd); end
    @(posedge clk); #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued: got busy %b want 0", busy1); end
  endtask

  task automatic test_settle();
    int sel_err, sv_err, bit_err;
    logic [4:0] es;
    logic       ev;
    sel_err = 0; sv_err = 0; bit_err = 0;
    glitch = 1'b1; mux2 = 32'h0000_000A;
    first2 = 5'd0; last2 = 5'd3; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0; first2 = 5'd9; last2 = 5'd9;
    for (int c = 0; c < 20; c++) begin
      es = 5'(c / 5);
      ev = ((c % 5) == 4);
      if (sel2 !== es || idx2 !== es) sel_err++;
      if (sv2 !== ev || done2 !== 1'b0) sv_err++;
      if (bit2 !== (ev ? mux2[es] : ~mux2[es])) bit_err++;
      @(posedge clk); #1;
    end
    n_cmp++; if (sel_err !== 0) begin n_fail++; $display("FAIL settle_hold: got %0d errors want 0", sel_err); end
    n_cmp++; if (sv_err !== 0 || bit_err !== 0) begin n_fail++; $display("FAIL settle_sample_timing: got %0d/%0d errors want 0/0", sv_err, bit_err); end
    n_cmp++; if (done2 !== 1'b1 || sel2 !== 5'd3) begin n_fail++; $display("FAIL settle_done: got %b/%0d want 1/3", done2, sel2); end
    n_cmp++; if (cap2 !== 32'h0000_000A) begin n_fail++; $display("FAIL settle_cap: got %0h want a", cap2); end
    @(posedge clk); #1;
    n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL settle_idle: got busy %b want 0", busy2); end
    glitch = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; glitch = 1'b0;
    first1 = '0; last1 = '0; first2 = '0; last2 = '0; mux1 = '0; mux2 = '0;
    test_reset();
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    test_full();
    test_wrap();
    test_single();
    test_reset_mid();
    test_back_to_back();
    test_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
